// File: rtl/commit_lockstep_ctrl.sv
// Lockstep commit scheduler for the two-copy harness: per-copy observation
// queues, in-order head comparison, clock-stall control and the drain/done sequence.

module commit_lockstep_q #(
  parameter int OBS_W = 64,
  parameter int DEPTH = 4,
  parameter int OW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [OBS_W-1:0] din,
  output logic [OBS_W-1:0] head,
  output logic [OW-1:0]    occ,
  output logic [OW-1:0]    occ_nxt
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][OBS_W-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;

  // Pointers wrap naturally (DEPTH is a power of two); fullness comes from occ.
  assign occ_nxt = occ + OW'(push) - OW'(pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module commit_lockstep_ctrl #(
  parameter int OBS_W     = 64,
  parameter int ADDR_W    = 40,
  parameter int DEPTH     = 4,
  parameter int DRAIN_MAX = 64,
  localparam int OW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_1,
  input  logic              commit_2,
  input  logic [OBS_W-1:0]  obs_1,
  input  logic [OBS_W-1:0]  obs_2,
  input  logic              addr_vld,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic              rob_empty_1,
  input  logic              rob_empty_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic [1:0]        state,
  output logic              deviation,
  output logic              invalid_program,
  output logic              finish,
  output logic              leak,
  output logic [OW-1:0]     occ_1,
  output logic [OW-1:0]     occ_2
);
  localparam int CW = $clog2(DRAIN_MAX);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dev_d, inv_d, fin_d, leak_d;
  logic [1:0]              stall_q, stall_d, push, commit;
  logic                    pop, mismatch, timing_dev, addr_dev;
  logic                    exit_a, exit_b, exit_c;
  logic [1:0][OBS_W-1:0]   obs, head;
  logic [1:0][OW-1:0]      occ, occ_nxt;
  logic [OW-1:0]           occ_diff;

  assign commit = {commit_2, commit_1};
  assign obs    = {obs_2, obs_1};
  assign push   = commit & ~stall_q;
  assign pop    = (occ[0] != '0) && (occ[1] != '0) && (state_q != DONE);

  for (genvar g = 0; g < 2; g++) begin : g_q
    commit_lockstep_q #(.OBS_W(OBS_W), .DEPTH(DEPTH), .OW(OW)) u_q (
      .clk     (clk),
      .rst     (rst),
      .push    (push[g]),
      .pop     (pop),
      .din     (obs[g]),
      .head    (head[g]),
      .occ     (occ[g]),
      .occ_nxt (occ_nxt[g])
    );
  end

  assign mismatch = pop && (head[0] != head[1]);
  assign occ_diff = (occ_nxt[0] > occ_nxt[1]) ? occ_nxt[0] - occ_nxt[1]
                                               : occ_nxt[1] - occ_nxt[0];
  // A one-entry skew is absorbed by the queues; only a wider gap counts.
  assign timing_dev = ~stall_q[0] & ~stall_q[1] & (commit_1 != commit_2) &
                      (occ_diff > OW'(1));
  assign addr_dev   = addr_vld & (addr_1 != addr_2);

  assign exit_a = rob_empty_1 & rob_empty_2 & (occ[0] == '0) & (occ[1] == '0);
  assign exit_b = ((occ[0] == '0) & rob_empty_2 & (occ[1] != '0)) |
                  ((occ[1] == '0) & rob_empty_1 & (occ[0] != '0));
  assign exit_c = (cnt_q == CW'(DRAIN_MAX - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dev_d   = deviation;
    inv_d   = invalid_program | mismatch;
    fin_d   = finish;
    case (state_q)
      RUN: begin
        if (timing_dev | addr_dev) begin
          dev_d   = 1'b1;
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (exit_a | exit_b | exit_c) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end
        // Uneven commit counts mean the two programs did not run alike.
        if (exit_b) inv_d = 1'b1;
      end
      DONE:    fin_d   = 1'b1;
      default: state_d = RUN;
    endcase
    for (int i = 0; i < 2; i++)
      stall_d[i] = (occ_nxt[i] == OW'(DEPTH)) | (state_d == DONE);
    leak_d = fin_d & dev_d & ~inv_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      cnt_q           <= '0;
      stall_q         <= '0;
      deviation       <= 1'b0;
      invalid_program <= 1'b0;
      finish          <= 1'b0;
      leak            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stall_q         <= stall_d;
      deviation       <= dev_d;
      invalid_program <= inv_d;
      finish          <= fin_d;
      leak            <= leak_d;
    end
  end

  assign state   = state_q;
  assign stall_1 = stall_q[0];
  assign stall_2 = stall_q[1];
  assign occ_1   = occ[0];
  assign occ_2   = occ[1];
endmodule

// File: tb/tb_commit_lockstep_ctrl.sv
// Self-checking bench for commit_lockstep_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.

module tb_commit_lockstep_ctrl;
  localparam int OBS_W = 64, ADDR_W = 40, DEPTH = 4, DRAIN_MAX = 64;
  localparam int OW = $clog2(DEPTH + 1);

  logic clk = 0, rst = 1;
  logic commit_1 = 0, commit_2 = 0, addr_vld = 0, rob_empty_1 = 0, rob_empty_2 = 0;
  logic [OBS_W-1:0]  obs_1 = '0, obs_2 = '0;
  logic [ADDR_W-1:0] addr_1 = '0, addr_2 = '0;
  logic stall_1, stall_2, deviation, invalid_program, finish, leak;
  logic [1:0] state;
  logic [OW-1:0] occ_1, occ_2;

  int errors = 0, checks = 0;

  commit_lockstep_ctrl #(.OBS_W(OBS_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                         .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .commit_1(commit_1), .commit_2(commit_2),
    .obs_1(obs_1), .obs_2(obs_2), .addr_vld(addr_vld), .addr_1(addr_1),
    .addr_2(addr_2), .rob_empty_1(rob_empty_1), .rob_empty_2(rob_empty_2),
    .stall_1(stall_1), .stall_2(stall_2), .state(state), .deviation(deviation),
    .invalid_program(invalid_program), .finish(finish), .leak(leak),
    .occ_1(occ_1), .occ_2(occ_2));

  always #5 clk = ~clk;

  // Behavioural model: two FIFOs of observations plus phase and sticky flags.
  logic [OBS_W-1:0] q1[$], q2[$];
  int  m_phase, m_cnt;
  bit  m_dev, m_inv, m_fin, m_leak, m_st1, m_st2;

  function automatic logic [12:0] mvec();
    return {m_st1, m_st2, 2'(m_phase), m_dev, m_inv, m_fin, m_leak,
            3'(q1.size()), 3'(q2.size())};
  endfunction

  function automatic logic [12:0] dvec();
    return {stall_1, stall_2, state, deviation, invalid_program, finish, leak,
            3'(occ_1), 3'(occ_2)};
  endfunction

  task automatic model_clear();
    q1.delete(); q2.delete();
    m_phase = 0; m_cnt = 0;
    {m_dev, m_inv, m_fin, m_leak, m_st1, m_st2} = '0;
  endtask

  // Advance one clock: model consumes the current inputs, DUT sees the edge.
  task automatic step();
    int s1, s2, n1, n2, d, np;
    bit p1, p2, popb, ea, eb, ec;
    s1 = q1.size(); s2 = q2.size();
    p1 = commit_1 && !m_st1;
    p2 = commit_2 && !m_st2;
    popb = (s1 > 0) && (s2 > 0) && (m_phase != 2);
    if (popb && (q1[0] != q2[0])) m_inv = 1;
    n1 = s1 + int'(p1) - int'(popb);
    n2 = s2 + int'(p2) - int'(popb);
    d  = (n1 > n2) ? n1 - n2 : n2 - n1;
    np = m_phase;
    if (m_phase == 0) begin
      if ((!m_st1 && !m_st2 && commit_1 != commit_2 && d > 1) ||
          (addr_vld && addr_1 != addr_2)) begin
        m_dev = 1; np = 1; m_cnt = 0;
      end
    end else if (m_phase == 1) begin
      ea = rob_empty_1 && rob_empty_2 && s1 == 0 && s2 == 0;
      eb = (s1 == 0 && rob_empty_2 && s2 > 0) || (s2 == 0 && rob_empty_1 && s1 > 0);
      ec = (m_cnt == DRAIN_MAX - 1);
      m_cnt++;
      if (ea || eb || ec) begin np = 2; m_fin = 1; end
      if (eb) m_inv = 1;
    end else m_fin = 1;
    if (popb) begin void'(q1.pop_front()); void'(q2.pop_front()); end
    if (p1) q1.push_back(obs_1);
    if (p2) q2.push_back(obs_2);
    m_phase = np;
    m_st1 = (n1 == DEPTH) || (np == 2);
    m_st2 = (n2 == DEPTH) || (np == 2);
    m_leak = m_fin && m_dev && !m_inv;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    commit_1 = 0; commit_2 = 0; addr_vld = 0;
    obs_1 = '0; obs_2 = '0; addr_1 = '0; addr_2 = '0;
    rob_empty_1 = 0; rob_empty_2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_clear();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dvec() !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dvec());
    end
    step();
    checks++;
    if (dvec() !== mvec()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", dvec(), mvec());
    end
  endtask

  task automatic test_lockstep();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      commit_1 = 1; commit_2 = 1; obs_1 = OBS_W'(i); obs_2 = OBS_W'(i);
      step();
      checks++;
      if (occ_1 > 1 || occ_2 > 1 || stall_1 || stall_2 || invalid_program ||
          state !== 2'd0 || dvec() !== mvec()) begin
        errors++; $display("FAIL lockstep[%0d]: got %h want %h", i, dvec(), mvec());
      end
    end
  endtask

  task automatic test_skew();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit_1 = 1; obs_1 = OBS_W'(i);
      step();
      if (i == 0) begin
        checks++;
        if (deviation !== 1'b0 || state !== 2'd0) begin
          errors++; $display("FAIL skew_tolerance: dev=%0b state=%0d want 0 0", deviation, state);
        end
      end
      if (i == 1) begin
        checks++;
        if (deviation !== 1'b1 || state !== 2'd1) begin
          errors++; $display("FAIL skew_deviation: dev=%0b state=%0d want 1 1", deviation, state);
        end
      end
    end
    checks++;
    if (occ_1 !== 3'd4 || stall_1 !== 1'b1 || dvec() !== mvec()) begin
      errors++; $display("FAIL skew_full: occ_1=%0d stall_1=%0b want 4 1", occ_1, stall_1);
    end
    commit_1 = 0;
    for (int i = 0; i < 4; i++) begin
      commit_2 = 1; obs_2 = OBS_W'(i);
      step();
    end
    commit_2 = 0;
    rob_empty_1 = 1; rob_empty_2 = 1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (finish !== 1'b1 || leak !== 1'b1 || invalid_program !== 1'b0 || state !== 2'd2 ||
        stall_1 !== 1'b1 || stall_2 !== 1'b1 || occ_1 !== 3'd0 || occ_2 !== 3'd0) begin
      errors++; $display("FAIL skew_done: got %h", dvec());
    end
    checks++;
    if (dvec() !== mvec()) begin
      errors++; $display("FAIL skew_model: got %h want %h", dvec(), mvec());
    end
  endtask

  task automatic test_isa_mismatch();
    do_reset();
    commit_1 = 1; commit_2 = 1; obs_1 = 64'h10; obs_2 = 64'h11;
    step();
    commit_1 = 0; commit_2 = 0;
    checks++;
    if (invalid_program !== 1'b0) begin
      errors++; $display("FAIL isa_early: inv=%0b want 0", invalid_program);
    end
    step();
    checks++;
    if (invalid_program !== 1'b1 || state !== 2'd0 || dvec() !== mvec()) begin
      errors++; $display("FAIL isa_mismatch: inv=%0b state=%0d want 1 0", invalid_program, state);
    end
    addr_vld = 1; addr_1 = 40'h100; addr_2 = 40'h200;
    step();
    addr_vld = 0; rob_empty_1 = 1; rob_empty_2 = 1;
    step();
    checks++;
    if (finish !== 1'b1 || leak !== 1'b0 || dvec() !== mvec()) begin
      errors++; $display("FAIL isa_leak: finish=%0b leak=%0b want 1 0", finish, leak);
    end
  endtask

  task automatic test_addr_dev();
    do_reset();
    addr_vld = 1; addr_1 = 40'h8000; addr_2 = 40'h8040;
    step();
    addr_vld = 0;
    checks++;
    if (state !== 2'd1 || deviation !== 1'b1 || finish !== 1'b0) begin
      errors++; $display("FAIL addr_drain: state=%0d dev=%0b want 1 1", state, deviation);
    end
    rob_empty_1 = 1; rob_empty_2 = 1;
    step();
    checks++;
    if (finish !== 1'b1 || leak !== 1'b1 || state !== 2'd2 || dvec() !== mvec()) begin
      errors++; $display("FAIL addr_done: finish=%0b leak=%0b want 1 1", finish, leak);
    end
  endtask

  task automatic test_drain_timeout();
    do_reset();
    addr_vld = 1; addr_1 = 40'h1; addr_2 = 40'h2;
    step();
    addr_vld = 0;
    for (int i = 0; i < DRAIN_MAX - 1; i++) step();
    checks++;
    if (finish !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL timeout_early: finish=%0b state=%0d want 0 1", finish, state);
    end
    step();
    checks++;
    if (finish !== 1'b1 || stall_1 !== 1'b1 || stall_2 !== 1'b1 || leak !== 1'b1 ||
        dvec() !== mvec()) begin
      errors++; $display("FAIL timeout_done: got %h want finish/stalls/leak set", dvec());
    end
  endtask

  task automatic test_count_imbalance();
    do_reset();
    commit_1 = 1; obs_1 = 64'h5;
    step();
    commit_1 = 0;
    addr_vld = 1; addr_1 = 40'h40; addr_2 = 40'h80;
    step();
    addr_vld = 0;
    checks++;
    if (state !== 2'd1 || occ_1 !== 3'd1 || occ_2 !== 3'd0) begin
      errors++; $display("FAIL imb_setup: state=%0d occ=%0d/%0d want 1 1/0", state, occ_1, occ_2);
    end
    rob_empty_1 = 1; rob_empty_2 = 1;
    step();
    checks++;
    if (finish !== 1'b1 || invalid_program !== 1'b1 || leak !== 1'b0 || dvec() !== mvec()) begin
      errors++; $display("FAIL imb_done: fin=%0b inv=%0b leak=%0b want 1 1 0", finish, invalid_program, leak);
    end
    // Asynchronous reset while draining.
    do_reset();
    commit_1 = 1; obs_1 = 64'h9;
    step();
    commit_1 = 0; addr_vld = 1; addr_1 = 40'h3; addr_2 = 40'h4;
    step();
    addr_vld = 0;
    step();
    #2 rst = 1;
    #1;
    checks++;
    if (dvec() !== 13'd0) begin
      errors++; $display("FAIL async_reset: got %h want 0", dvec());
    end
    model_clear();
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      commit_1    = ($urandom_range(0, 99) < 60);
      commit_2    = ($urandom_range(0, 99) < 60);
      obs_1       = OBS_W'($urandom_range(0, 3));
      obs_2       = ($urandom_range(0, 9) < 8) ? obs_1 : OBS_W'($urandom_range(0, 3));
      addr_vld    = ($urandom_range(0, 99) < 4);
      addr_1      = ADDR_W'($urandom_range(0, 1));
      addr_2      = ADDR_W'($urandom_range(0, 1));
      rob_empty_1 = ($urandom_range(0, 99) < 25);
      rob_empty_2 = ($urandom_range(0, 99) < 25);
      step();
      checks++;
      if (dvec() !== mvec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, dvec(), mvec());
      end
      if (m_fin && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_skew();
    test_isa_mismatch();
    test_addr_dev();
    test_drain_timeout();
    test_count_imbalance();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_lockstep_ctrl.md
# commit_lockstep_ctrl

Lockstep scheduler for the two-copy BOOM harness. It buffers each copy's committed-instruction ISA observations in a small per-copy queue. It drives the per-copy clock-stall requests so the two commit streams are compared in order. It also sequences the deviation → drain → done flow that ends a check. It sits in the top-level harness between the copies' ROB commit/LSU taps and the property logic that consumes `finish`, `leak` and `invalid_program`.

## Interface
- `OBS_W`, 64: width of one committed-instruction ISA observation (contract-filtered rs1/rs2/address).
- `ADDR_W`, 40: width of the data-memory request address tap.
- `DEPTH`, 4: per-copy observation queue depth, power of two ≥2.
- `DRAIN_MAX`, 64: maximum drain cycles before forced completion.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `commit_1`, `commit_2` in 1: copy N retires an instruction this cycle.
- `obs_1`, `obs_2` in OBS_W: ISA observation of the retiring instruction, valid with `commit_N`.
- `addr_vld` in 1: both dmem address taps are meaningful this cycle.
- `addr_1`, `addr_2` in ADDR_W: dmem request address of each copy.
- `rob_empty_1`, `rob_empty_2` in 1: copy N ROB holds no valid entries.
- `stall_1`, `stall_2` out 1: gate copy N's clock (registered).
- `state` out 2: 0=RUN, 1=DRAIN, 2=DONE.
- `deviation` out 1: sticky, microarchitectural deviation seen.
- `invalid_program` out 1: sticky, ISA observations differ.
- `finish` out 1: sticky, check complete.
- `leak` out 1: registered, `finish & deviation & ~invalid_program`.
- `occ_1`, `occ_2` out $clog2(DEPTH+1): queue occupancies.

## Operation
- Push: `commit_N & ~stall_N` writes `obs_N` at queue N's tail. A commit while `stall_N` is ignored and not pushed.
- Pop/compare: when both queues are non-empty, both heads pop in the same cycle. Heads unequal → `invalid_program` ← 1.
- Push and pop of the same queue in one cycle are both applied; occupancy stays unchanged.
- Stall: `stall_N` ← (next `occ_N` == DEPTH), or `state`==DONE. When `occ_N` reaches DEPTH, copy N halts until the other copy catches up.
- Timing deviation: in RUN, with `~stall_1 & ~stall_2 & (commit_1 != commit_2)`, the tolerance is consumed by buffering. The deviation is recorded only when `|occ_1 − occ_2|` would exceed 1 after the update.
- Address deviation: in RUN, `addr_vld & (addr_1 != addr_2)`.
- Either deviation → `deviation` ← 1, state → DRAIN, drain counter ← 0.
- DRAIN: pushes and compares continue. The counter increments every cycle. Exit to DONE occurs when any of these holds:
  - (a) both `rob_empty_N` and both queues empty;
  - (b) one queue is empty, the other copy's ROB is empty and its queue is non-empty;
  - (c) the counter reaches DRAIN_MAX−1.
- Exit (b) sets `invalid_program`, because commit counts differ.
- DONE: `finish` ← 1, both stalls ← 1. Held until reset. `leak` is valid from the cycle `finish` is high.
- Deviation in DRAIN: no effect, because the flag is already sticky.
- An ISA mismatch in RUN sets only `invalid_program`; state stays RUN.

## Timing
- Reset values: all outputs 0, state RUN, queues empty, counter 0. Async assertion clears immediately, including mid-DRAIN.
- Compare latency: the mismatch flag is visible 1 cycle after the pop cycle.
- Stall latency: the stall is asserted the cycle after the push that fills the queue. It deasserts the cycle after the pop that frees a slot.
- RUN→DRAIN: `state` updates 1 cycle after the deviating input cycle.
- DRAIN→DONE: `finish` and `leak` rise 1 cycle after the exit condition.
- Pointer wrap: modulo DEPTH. Full is distinguished by occupancy, not by pointers.

## Test plan
- Lockstep equal stream: commit both copies every cycle for 10 cycles with `obs`=i → `occ` ≤1, no stall, `invalid_program`=0, state RUN.
- Skewed commit: copy1 commits for 4 cycles while copy2 is idle, DEPTH=4 → `occ_1`=4 and `stall_1`=1 after cycle 4. Also `deviation`=1 and DRAIN from the 2-difference point. Then copy2 commits 4 equal obs → queues empty, with both ROBs empty → DONE, `leak`=1.
- ISA mismatch: both copies commit, obs 0x10 vs 0x11 → `invalid_program`=1 the next cycle, state RUN, `leak`=0 at finish.
- Address deviation: `addr_vld`=1, addr 0x8000 vs 0x8040 → DRAIN next cycle. With both ROBs empty and queues empty → `finish`=1, `leak`=1.
- Drain timeout: enter DRAIN, hold `rob_empty_*`=0 and no commits → `finish`=1 exactly DRAIN_MAX cycles after entry, both stalls=1.
- Count imbalance: in DRAIN, copy1 queue holds 1 entry, `rob_empty_1`=1, copy2 queue empty, `rob_empty_2`=1 → DONE with `invalid_program`=1. Asserting `rst` mid-DRAIN clears all outputs asynchronously.
